// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU units (adder and subtractor).
package serial_alu_pkg;

  // Control states of the serial datapath sequencer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operand width both serial units default to, so they stay interchangeable
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic In_A,
  input  logic In_B,
  input  logic Carry_in,
  output logic Sum,
  output logic Carry_out
);

  // Sum is the parity of the three inputs, carry is their majority
  always_comb begin
    Sum       = In_A ^ In_B ^ Carry_in;
    Carry_out = (In_A & In_B) | (In_A & Carry_in) | (In_B & Carry_in);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, WIDTH cycles per add, start/done handshake.
module serial_adder
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  input  logic             Carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out
);

  // One extra counter bit keeps WIDTH=1 from collapsing to a zero-width counter
  localparam int CW  = $clog2(WIDTH) + 1;
  // The partial-sum register only needs the bits already produced before the last one
  localparam int SRW = (WIDTH > 1) ? WIDTH - 1 : 1;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [SRW-1:0]   sum_sr;
  logic [SRW-1:0]   sum_sr_next;
  logic [WIDTH-1:0] sum_shift;
  logic             c_reg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_out_reg;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  full_adder u_full_adder (
    .In_A      (a_sr[0]),
    .In_B      (b_sr[0]),
    .Carry_in  (c_reg),
    .Sum       (fa_sum),
    .Carry_out (fa_carry)
  );

  // New sum bit enters at the MSB; earlier bits slide toward the LSB
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift   = fa_sum;
      assign sum_sr_next = 1'b0;
    end else begin : g_wn
      assign sum_shift   = {fa_sum, sum_sr};
      assign sum_sr_next = sum_shift[WIDTH-1:1];
    end
  endgenerate

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start only matters while idle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Operand capture on accept, then one bit of addition per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      c_reg   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr    <= In_A;
            b_sr    <= In_B;
            c_reg   <= Carry_in;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_sr_next;
          c_reg   <= fa_carry;
          bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers update only when the final bit is produced, then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
    end else if (state_reg == SHIFT && last_bit) begin
      sum_reg       <= sum_shift;
      carry_out_reg <= fa_carry;
    end
  end

  assign Sum       = sum_reg;
  assign Carry_out = carry_out_reg;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder: latches two WIDTH-bit operands and a carry-in on a start request, then adds them LSB-first, one bit per clock, through a single full-adder cell. It is the addition counterpart to the team's subtractor datapath. It trades WIDTH cycles of latency for one adder cell, and sits in the lab ALU path as the area-minimal add unit behind a start/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- In_A  input  WIDTH  operand A; sampled on the accepted start edge.
- In_B  input  WIDTH  operand B; sampled on the accepted start edge.
- Carry_in  input  1  initial carry; sampled on the accepted start edge.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- Sum  output  WIDTH  registered result, (In_A + In_B + Carry_in) mod 2^WIDTH.
- Carry_out  output  1  registered carry out of bit WIDTH-1.

## Operation
- FSM states:
  - IDLE: start=1 latches In_A, In_B and Carry_in into a_sr, b_sr and c_reg, clears bit_cnt, and moves to SHIFT. start=0 stays in IDLE.
  - SHIFT: each cycle the full adder computes s = a_sr[0]^b_sr[0]^c_reg and co = majority(a_sr[0], b_sr[0], c_reg).
    - s shifts into sum_sr at its MSB; a_sr and b_sr shift right by one; c_reg <= co; bit_cnt increments.
    - When bit_cnt == WIDTH-1, the FSM moves to DONE, loads Sum from the final shifted value and loads Carry_out from co.
  - DONE: done=1 for exactly this cycle; the FSM always returns to IDLE next cycle.
- start is ignored in SHIFT and DONE. No queuing: a request while busy is lost.
- Sum and Carry_out change only on the SHIFT->DONE transition. They hold their value through IDLE until the next result is produced.
- bit_cnt width is $clog2(WIDTH)+1, so WIDTH=1 needs no special case.
- In_A, In_B and Carry_in may change freely after the accepted start edge.

## Timing
- Reset (rst_n=0, any time, including mid-SHIFT):
  - FSM goes to IDLE immediately.
  - busy, done, Sum and Carry_out go to 0; all internal shift registers, c_reg and bit_cnt go to 0.
  - The operation in progress is discarded.
- Latency: start accepted at edge N. SHIFT occupies edges N+1..N+WIDTH. done is high in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles after the request edge.
- busy rises the cycle after the accepting edge and falls together with done.
- Throughput: one operation per WIDTH+2 cycles. The earliest next acceptance is the IDLE cycle after DONE.
- Simultaneous events:
  - start high during DONE is ignored. It must still be high in the following IDLE cycle to be accepted.
  - Reset wins over every other event.

## Structure
- Shared package serial_alu_pkg holds:
  - the state enum (IDLE, SHIFT, DONE), 2-bit encoding;
  - the default WIDTH constant, so the subtractor and adder units agree.
- One sub-module, full_adder: a purely combinational cell with ports In_A, In_B, Carry_in, Sum, Carry_out. It is instantiated once.
- Top level holds the FSM, operand and sum shift registers, c_reg, bit_cnt and the output registers.

## Test plan
- 0x3C + 0x5A, Carry_in=0 -> done after 9 cycles; Sum=0x96, Carry_out=0; busy high for exactly 9 cycles.
- 0xFF + 0x01, Carry_in=0 -> Sum=0x00, Carry_out=1. Also 0xFF + 0x00, Carry_in=1 -> Sum=0x00, Carry_out=1.
- Start 0x10 + 0x20, then pulse start with 0xAA + 0x55 during SHIFT -> second request ignored; Sum=0x30; no extra done pulse.
- rst_n low at the 4th SHIFT cycle of 0x7F + 0x7F -> immediately busy=0, done=0, Sum=0x00. A fresh 0x01 + 0x02 then yields Sum=0x03.
- start held high continuously with operands 0x80 + 0x80 -> operations repeat every 10 cycles; each yields Sum=0x00, Carry_out=1 with a single-cycle done.
- WIDTH=1 build: 1 + 1, Carry_in=1 -> done 2 cycles after the request; Sum=1, Carry_out=1.
